// File: rtl/arps_pkg.sv
// Shared types and constants for the ARPS motion-vector writer.
package arps_pkg;

    localparam int          MV_W           = 8;
    localparam int          SAD_W          = 16;
    localparam logic [3:0]  MV_BRAM_WE_ALL = 4'hF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } mvw_state_e;

    typedef struct packed {
        logic [SAD_W-1:0] sad;
        logic [MV_W-1:0]  mv_y;
        logic [MV_W-1:0]  mv_x;
    } mv_word_t;

    // Build the 32-bit BRAM word; components pass through as raw two's complement.
    function automatic logic [31:0] pack_mv(input logic [MV_W-1:0]  mv_x,
                                            input logic [MV_W-1:0]  mv_y,
                                            input logic [SAD_W-1:0] sad);
        mv_word_t w;
        w.sad  = sad;
        w.mv_y = mv_y;
        w.mv_x = mv_x;
        return w;
    endfunction

endpackage

// File: rtl/arps_mv_fifo.sv
// Synchronous FIFO with push/pop, full/empty flags and occupancy count.
module arps_mv_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign count     = wr_ptr_r - rd_ptr_r;
    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == {CW{1'b0}});
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;
    assign dout      = mem_r[rd_ptr_r[AW-1:0]];

    // Pointer update; reset discards whatever is buffered.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {CW{1'b0}};
            rd_ptr_r <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/arps_mv_writer.sv
// Buffers ARPS motion vectors and writes one 32-bit word per macroblock into the MV BRAM.
// Optional macro ARPS_MV_SAD_EN: store SAD in data_mv[31:16] (otherwise those bits are zero).
module arps_mv_writer
    import arps_pkg::*;
#(
    parameter int MB_COUNT   = 1024,
    parameter int FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic            mv_valid_i,
    output logic            mv_ready_o,
    input  logic [MV_W-1:0] mv_x_i,
    input  logic [MV_W-1:0] mv_y_i,
    input  logic [15:0]     sad_i,
    output logic            clk_mv,
    output logic            rst_mv,
    output logic [31:0]     addr_mv,
    output logic [31:0]     data_mv,
    output logic            en_mv,
    output logic [3:0]      we_mv,
    output logic            busy_o,
    output logic [15:0]     mb_done_o,
    input  logic            irq_clear_i,
    output logic            interrupt_o
);

`ifdef ARPS_MV_SAD_EN
    localparam int FIFO_W = SAD_W + 2 * MV_W;
`else
    localparam int FIFO_W = 2 * MV_W;
`endif
    localparam logic [15:0] MB_CNT16 = 16'(MB_COUNT);
    localparam int          FCW      = $clog2(FIFO_DEPTH) + 1;

    mvw_state_e        state_r;
    mvw_state_e        state_nx_s;
    logic [15:0]       accepted_r;
    logic [15:0]       written_r;
    logic              busy_r;
    logic              irq_r;
    logic              push_s;
    logic              pop_s;
    logic              start_go_s;
    logic              last_write_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [FIFO_W-1:0] fifo_din_s;
    logic [FIFO_W-1:0] fifo_dout_s;
    logic [SAD_W-1:0]  sad_word_s;
    logic [FCW-1:0]    fifo_count_unused_s;

`ifdef ARPS_MV_SAD_EN
    assign fifo_din_s = {sad_i, mv_y_i, mv_x_i};
    assign sad_word_s = fifo_dout_s[FIFO_W-1:2*MV_W];
`else
    logic sad_unused_s;
    assign sad_unused_s = ^sad_i;
    assign fifo_din_s   = {mv_y_i, mv_x_i};
    assign sad_word_s   = 16'h0000;
`endif

    assign clk_mv       = clk;
    assign rst_mv       = rst;
    assign mv_ready_o   = (state_r == RUN) & ~fifo_full_s & (accepted_r < MB_CNT16);
    assign push_s       = mv_valid_i & mv_ready_o;
    assign pop_s        = ~fifo_empty_s & ((state_r == RUN) | (state_r == DRAIN));
    assign start_go_s   = start_i & ((state_r == IDLE) | (state_r == DONE));
    assign last_write_s = pop_s & (written_r == (MB_CNT16 - 16'd1));
    assign busy_o       = busy_r;
    assign interrupt_o  = irq_r;
    assign mb_done_o    = written_r;

    arps_mv_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FIFO_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .din   (fifo_din_s),
        .pop   (pop_s),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_unused_s)
    );

    // Frame sequencing; the last write can land while still in RUN, so both states watch it.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_i) state_nx_s = RUN;
                else         state_nx_s = IDLE;
            end
            RUN: begin
                if (last_write_s)                state_nx_s = DONE;
                else if (accepted_r == MB_CNT16) state_nx_s = DRAIN;
                else                             state_nx_s = RUN;
            end
            DRAIN: begin
                if (last_write_s) state_nx_s = DONE;
                else              state_nx_s = DRAIN;
            end
            DONE: begin
                if (start_i) state_nx_s = RUN;
                else         state_nx_s = DONE;
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // State, counters, status and interrupt registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            accepted_r <= 16'd0;
            written_r  <= 16'd0;
            busy_r     <= 1'b0;
            irq_r      <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            busy_r  <= (state_nx_s == RUN) | (state_nx_s == DRAIN);
            if (start_go_s) begin
                accepted_r <= 16'd0;
                written_r  <= 16'd0;
                irq_r      <= 1'b0;
            end else begin
                if (push_s) accepted_r <= accepted_r + 16'd1;
                if (pop_s)  written_r  <= written_r + 16'd1;
                if (last_write_s) begin
                    irq_r <= 1'b1;
                end else if (irq_clear_i && (state_r == DONE)) begin
                    irq_r <= 1'b0;
                end
            end
        end
    end

    // BRAM write port; address and data hold when nothing is popped.
    always_ff @(posedge clk) begin
        if (rst) begin
            en_mv   <= 1'b0;
            we_mv   <= 4'h0;
            addr_mv <= 32'd0;
            data_mv <= 32'd0;
        end else if (pop_s) begin
            en_mv   <= 1'b1;
            we_mv   <= MV_BRAM_WE_ALL;
            addr_mv <= {14'd0, written_r, 2'b00};
            data_mv <= pack_mv(fifo_dout_s[MV_W-1:0], fifo_dout_s[2*MV_W-1:MV_W], sad_word_s);
        end else begin
            en_mv   <= 1'b0;
            we_mv   <= 4'h0;
        end
    end

endmodule

// File: tb/tb_arps_mv_writer.sv
// Self-checking bench for arps_mv_writer: vector table, corner-case sequences, randomized frames vs. model.
module tb_arps_mv_writer;

    localparam int MB    = 4;
    localparam int DEPTH = 2;
`ifdef ARPS_MV_SAD_EN
    localparam bit SAD_EN = 1'b1;
`else
    localparam bit SAD_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, start_i, mv_valid_i, irq_clear_i;
    logic [7:0]  mv_x_i, mv_y_i;
    logic [15:0] sad_i;
    logic        mv_ready_o, clk_mv, rst_mv, en_mv, busy_o, interrupt_o;
    logic [31:0] addr_mv, data_mv;
    logic [3:0]  we_mv;
    logic [15:0] mb_done_o;

    always #5 clk = ~clk;

    arps_mv_writer #(.MB_COUNT(MB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .mv_valid_i(mv_valid_i), .mv_ready_o(mv_ready_o),
        .mv_x_i(mv_x_i), .mv_y_i(mv_y_i), .sad_i(sad_i), .clk_mv(clk_mv), .rst_mv(rst_mv),
        .addr_mv(addr_mv), .data_mv(data_mv), .en_mv(en_mv), .we_mv(we_mv), .busy_o(busy_o),
        .mb_done_o(mb_done_o), .irq_clear_i(irq_clear_i), .interrupt_o(interrupt_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Behavioural model: a frame is "active" from start until MB words are written.
    bit          m_active = 1'b0;
    bit          m_irq    = 1'b0;
    int          m_acc    = 0;
    int          m_wr     = 0;
    logic [31:0] m_q[$];
    logic        m_en     = 1'b0;
    logic [3:0]  m_we     = 4'h0;
    logic [31:0] m_addr   = 32'd0;
    logic [31:0] m_data   = 32'd0;
    logic [31:0] cap_addr[$];
    logic [31:0] cap_data[$];

    function automatic bit m_ready();
        return m_active && (m_acc < MB) && (m_q.size() < DEPTH);
    endfunction

    task automatic step(output bit xfer);
        bit rdy, was_active;
        rdy        = m_ready();
        was_active = m_active;
        xfer       = 1'b0;
        @(posedge clk);
        if (rst) begin
            m_active = 1'b0; m_irq = 1'b0; m_acc = 0; m_wr = 0; m_q.delete();
            m_en = 1'b0; m_we = 4'h0; m_addr = 32'd0; m_data = 32'd0;
        end else begin
            m_en = 1'b0;
            m_we = 4'h0;
            if (m_q.size() > 0) begin
                m_en   = 1'b1;
                m_we   = 4'hF;
                m_addr = m_wr * 4;
                m_data = m_q.pop_front();
                m_wr++;
                if (m_wr == MB) begin
                    m_active = 1'b0;
                    m_irq    = 1'b1;
                end
            end
            if (mv_valid_i && rdy) begin
                m_q.push_back({(SAD_EN ? sad_i : 16'h0000), mv_y_i, mv_x_i});
                m_acc++;
                xfer = 1'b1;
            end
            if (start_i && !was_active) begin
                m_active = 1'b1; m_acc = 0; m_wr = 0; m_irq = 1'b0;
            end else if (irq_clear_i && !was_active) begin
                m_irq = 1'b0;
            end
        end
        #1;
        chk("ready", {31'd0, mv_ready_o}, {31'd0, m_ready()});
        chk("en_mv", {31'd0, en_mv}, {31'd0, m_en});
        chk("we_mv", {28'd0, we_mv}, {28'd0, m_we});
        chk("addr_mv", addr_mv, m_addr);
        chk("data_mv", data_mv, m_data);
        chk("busy", {31'd0, busy_o}, {31'd0, m_active});
        chk("irq", {31'd0, interrupt_o}, {31'd0, m_irq});
        chk("mb_done", {16'd0, mb_done_o}, m_wr);
        if (en_mv) begin
            cap_addr.push_back(addr_mv);
            cap_data.push_back(data_mv);
        end
    endtask

    task automatic idle(input int n);
        bit x;
        repeat (n) step(x);
    endtask

    task automatic pulse_start();
        bit x;
        start_i = 1'b1;
        step(x);
        start_i = 1'b0;
    endtask

    task automatic send(input logic [7:0] x, input logic [7:0] y, input logic [15:0] s);
        bit ok;
        ok = 1'b0;
        mv_valid_i = 1'b1; mv_x_i = x; mv_y_i = y; sad_i = s;
        for (int i = 0; i < 20 && !ok; i++) step(ok);
        mv_valid_i = 1'b0;
        chk("send_accept", {31'd0, ok}, 32'd1);
    endtask

    typedef struct {
        logic [7:0]  x;
        logic [7:0]  y;
        logic [15:0] sad;
        logic [31:0] data_nosad;
        logic [31:0] data_sad;
        logic [31:0] addr;
    } vec_t;

    vec_t tbl[4];

    initial begin
        bit x;
        tbl[0] = '{8'd1,   8'hFF, 16'd5, 32'h0000FF01, 32'h0005FF01, 32'd0};
        tbl[1] = '{8'd2,   8'hFE, 16'd6, 32'h0000FE02, 32'h0006FE02, 32'd4};
        tbl[2] = '{8'd3,   8'hFD, 16'd7, 32'h0000FD03, 32'h0007FD03, 32'd8};
        tbl[3] = '{8'd127, 8'h80, 16'd8, 32'h0000807F, 32'h0008807F, 32'd12};

        rst = 1'b1; start_i = 1'b0; mv_valid_i = 1'b0; irq_clear_i = 1'b0;
        mv_x_i = 8'd0; mv_y_i = 8'd0; sad_i = 16'd0;
        idle(2);
        rst = 1'b0;
        idle(2);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_ready", {31'd0, mv_ready_o}, 32'd0);

        // Basic frame from the vector table
        cap_addr.delete(); cap_data.delete();
        pulse_start();
        chk("ready_after_start", {31'd0, mv_ready_o}, 32'd1);
        foreach (tbl[i]) send(tbl[i].x, tbl[i].y, tbl[i].sad);
        idle(4);
        chk("basic_nwrites", cap_addr.size(), 32'd4);
        for (int i = 0; i < 4 && i < cap_addr.size(); i++) begin
            chk("basic_addr", cap_addr[i], tbl[i].addr);
            chk("basic_data", cap_data[i], SAD_EN ? tbl[i].data_sad : tbl[i].data_nosad);
        end
        chk("basic_irq", {31'd0, interrupt_o}, 32'd1);
        chk("basic_done", {16'd0, mb_done_o}, 32'd4);

        // Interrupt clear, then clear+start together (start wins)
        irq_clear_i = 1'b1; step(x); irq_clear_i = 1'b0;
        chk("irq_cleared", {31'd0, interrupt_o}, 32'd0);
        chk("irq_clr_done_kept", {16'd0, mb_done_o}, 32'd4);
        pulse_start();
        foreach (tbl[i]) send(tbl[i].x, tbl[i].y, tbl[i].sad);
        idle(3);
        chk("irq_set2", {31'd0, interrupt_o}, 32'd1);
        irq_clear_i = 1'b1; start_i = 1'b1; step(x); irq_clear_i = 1'b0; start_i = 1'b0;
        chk("clr_start_busy", {31'd0, busy_o}, 32'd1);
        chk("clr_start_cnt", {16'd0, mb_done_o}, 32'd0);

        // Backpressure: 5th vector held valid is never accepted
        cap_addr.delete(); cap_data.delete();
        foreach (tbl[i]) send(tbl[i].x, tbl[i].y, tbl[i].sad);
        mv_valid_i = 1'b1; mv_x_i = 8'h55; mv_y_i = 8'hAA; sad_i = 16'h1234;
        for (int i = 0; i < 6; i++) begin
            step(x);
            chk("bp_ready", {31'd0, mv_ready_o}, 32'd0);
        end
        mv_valid_i = 1'b0;
        chk("bp_done", {16'd0, mb_done_o}, 32'd4);
        chk("bp_nwrites", cap_addr.size(), 32'd4);

        // start_i mid-frame is ignored
        cap_addr.delete(); cap_data.delete();
        pulse_start();
        send(8'd9, 8'd8, 16'd1);
        send(8'd7, 8'd6, 16'd2);
        idle(1);
        pulse_start();
        chk("midstart_busy", {31'd0, busy_o}, 32'd1);
        chk("midstart_cnt", {16'd0, mb_done_o}, 32'd2);
        send(8'd5, 8'd4, 16'd3);
        send(8'd3, 8'd2, 16'd4);
        idle(3);
        chk("midstart_last", cap_addr.size() > 0 ? cap_addr[cap_addr.size()-1] : 32'hFFFF_FFFF, 32'd12);
        chk("midstart_done", {16'd0, mb_done_o}, 32'd4);

        // Reset mid-frame with vectors in flight
        cap_addr.delete(); cap_data.delete();
        pulse_start();
        send(8'd1, 8'd2, 16'd3);
        mv_valid_i = 1'b1; mv_x_i = 8'd4; mv_y_i = 8'd5;
        rst = 1'b1;
        idle(3);
        rst = 1'b0; mv_valid_i = 1'b0;
        cap_addr.delete(); cap_data.delete();
        chk("midrst_en", {31'd0, en_mv}, 32'd0);
        chk("midrst_addr", addr_mv, 32'd0);
        chk("midrst_data", data_mv, 32'd0);
        chk("midrst_done", {16'd0, mb_done_o}, 32'd0);
        idle(5);
        chk("midrst_nowrite", cap_addr.size(), 32'd0);

        // Randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            start_i     = ($urandom_range(0, 9) == 0);
            irq_clear_i = ($urandom_range(0, 7) == 0);
            mv_valid_i  = ($urandom_range(0, 2) != 0);
            mv_x_i      = 8'($urandom);
            mv_y_i      = 8'($urandom);
            sad_i       = 16'($urandom);
            rst         = ($urandom_range(0, 149) == 0);
            step(x);
        end
        rst = 1'b0; start_i = 1'b0; irq_clear_i = 1'b0; mv_valid_i = 1'b0;
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
